// File: rtl/mdu_seq_64bit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer for the MIPS core. It drives an
// external 64-bit adder/subtractor every cycle and holds the HI/LO results.
module mdu_seq_64bit (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_by_zero,
    output logic [63:0] add_a,
    output logic [63:0] add_b,
    output logic        add_cin,
    input  logic [63:0] add_out,
    input  logic        add_cout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_NEG_A,
        S_NEG_B,
        S_ITER,
        S_FIX1,
        S_FIX2,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_busy;
    logic        r_done;
    logic        r_is_div;
    logic        r_sign_a;
    logic        r_sign_b;
    logic        r_dbz;
    logic [4:0]  r_cnt;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [63:0] r_acc;
    logic [63:0] r_mc;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [63:0] w_add_a;
    logic [63:0] w_add_b;
    logic        w_add_cin;
    logic        w_div_zero;
    logic        w_unused;

    // Carry-out is not needed: sign of a divide step comes from add_out[63].
    assign w_unused   = add_cout;
    assign w_div_zero = op[1] && (rt == 32'd0);

    assign busy        = r_busy;
    assign done        = r_done;
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign div_by_zero = r_dbz;
    assign add_a       = w_add_a;
    assign add_b       = w_add_b;
    assign add_cin     = w_add_cin;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != S_IDLE);
            r_done  <= (w_next == S_DONE);
        end
    end

    always_comb begin
        w_next    = r_state;
        w_add_a   = 64'd0;
        w_add_b   = 64'd0;
        w_add_cin = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = w_div_zero ? S_DONE : S_NEG_A;
                end
            end
            S_NEG_A: begin
                w_next = S_NEG_B;
                if (r_sign_a) begin
                    w_add_b   = {32'd0, r_a};
                    w_add_cin = 1'b1;
                end
            end
            S_NEG_B: begin
                w_next = S_ITER;
                if (r_sign_b) begin
                    w_add_b   = {32'd0, r_b};
                    w_add_cin = 1'b1;
                end
            end
            S_ITER: begin
                if (r_cnt == 5'd31) begin
                    w_next = S_FIX1;
                end
                // Divide: trial-subtract divisor from {rem, next dividend bit}.
                if (r_is_div) begin
                    w_add_a   = {31'd0, r_acc[31:0], r_a[31]};
                    w_add_b   = {32'd0, r_b};
                    w_add_cin = 1'b1;
                end else if (r_b[0]) begin
                    w_add_a = r_acc;
                    w_add_b = r_mc;
                end
            end
            S_FIX1: begin
                w_next = S_FIX2;
                if (r_sign_a ^ r_sign_b) begin
                    w_add_b   = r_is_div ? {32'd0, r_a} : r_acc;
                    w_add_cin = 1'b1;
                end
            end
            S_FIX2: begin
                w_next = S_DONE;
                if (r_is_div && r_sign_a) begin
                    w_add_b   = {32'd0, r_acc[31:0]};
                    w_add_cin = 1'b1;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // r_a doubles as the shifting dividend/quotient; r_b as the shifting multiplier.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_is_div <= 1'b0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_dbz    <= 1'b0;
            r_cnt    <= 5'd0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_acc    <= 64'd0;
            r_mc     <= 64'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_is_div <= op[1];
                        r_sign_a <= rs[31] & op[0];
                        r_sign_b <= rt[31] & op[0];
                        r_a      <= rs;
                        r_b      <= rt;
                        r_acc    <= 64'd0;
                        r_mc     <= 64'd0;
                        r_cnt    <= 5'd0;
                        r_dbz    <= 1'b0;
                        if (w_div_zero) begin
                            r_hi  <= rs;
                            r_lo  <= 32'hFFFF_FFFF;
                            r_dbz <= 1'b1;
                        end
                    end
                end
                S_NEG_A: begin
                    if (r_sign_a) begin
                        r_a <= add_out[31:0];
                    end
                end
                S_NEG_B: begin
                    if (r_sign_b) begin
                        r_b <= add_out[31:0];
                    end
                    r_mc  <= {32'd0, r_a};
                    r_cnt <= 5'd0;
                end
                S_ITER: begin
                    r_cnt <= r_cnt + 5'd1;
                    if (r_is_div) begin
                        if (!add_out[63]) begin
                            r_acc[31:0] <= add_out[31:0];
                            r_a         <= {r_a[30:0], 1'b1};
                        end else begin
                            r_acc[31:0] <= {r_acc[30:0], r_a[31]};
                            r_a         <= {r_a[30:0], 1'b0};
                        end
                    end else begin
                        if (r_b[0]) begin
                            r_acc <= add_out;
                        end
                        r_mc <= {r_mc[62:0], 1'b0};
                        r_b  <= {1'b0, r_b[31:1]};
                    end
                end
                S_FIX1: begin
                    if (r_sign_a ^ r_sign_b) begin
                        if (r_is_div) begin
                            r_a <= add_out[31:0];
                        end else begin
                            r_acc <= add_out;
                        end
                    end
                end
                S_FIX2: begin
                    if (r_is_div) begin
                        r_lo <= r_a;
                        r_hi <= r_sign_a ? add_out[31:0] : r_acc[31:0];
                    end else begin
                        r_hi <= r_acc[63:32];
                        r_lo <= r_acc[31:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
